// File: rtl/fpcvt_sched_pkg.sv
// fpcvt_sched_pkg
// Shared definitions for the fpcvt_sched block:
//   - datapath widths and the saturation constants of the 12-bit to 8-bit
//     float conversion (sign, 3-bit exponent, 4-bit significand)
//   - scheduler state encoding
//   - abs_sat(): two's-complement to 11-bit magnitude with -2048 saturation
package fpcvt_sched_pkg;

  localparam int DATA_W = 12;
  localparam int MAG_W  = 11;
  localparam int EXP_W  = 3;
  localparam int SIG_W  = 4;

  localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;
  localparam logic [SIG_W-1:0] SIG_MAX = 4'd15;
  localparam logic [MAG_W-1:0] MAG_SAT = 11'd2047;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    RESP  = 2'd3
  } state_t;

  // The most negative input has no 11-bit magnitude, so it clamps to MAG_SAT.
  function automatic logic [MAG_W-1:0] abs_sat(input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] neg;
    neg = -data;
    if (data == {1'b1, {(DATA_W-1){1'b0}}})
      return MAG_SAT;
    else if (data[DATA_W-1])
      return neg[MAG_W-1:0];
    else
      return data[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/fpcvt_rr_arbiter.sv
// fpcvt_rr_arbiter
// Purely combinational round-robin grant generator. The pointer register
// lives in the parent; this block only searches upward from it.
// Ports:
//   req_valid [NREQ]  per-requester valid
//   pointer   [ID_W]  index with highest priority this cycle
//   enable            when low, no grant is issued
//   grant     [NREQ]  one-hot grant (all zeros if nothing valid/enabled)
module fpcvt_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [ID_W-1:0] pointer,
  input  logic            enable,
  output logic [NREQ-1:0] grant
);

  logic found;

  // Walk the requesters in priority order starting at the pointer, wrapping
  // at NREQ, and grant the first one that is valid.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && enable && req_valid[i] &&
            (i == ((int'(pointer) + off) % NREQ))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fpcvt_sched.sv
// fpcvt_sched
// Shares one 12-bit two's-complement to 8-bit float converter among NREQ
// requesters. One sample is in flight at a time: IDLE accepts, NORM shifts
// the magnitude left once per cycle, ROUND forms the result, RESP holds it
// until the consumer takes it.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid [NREQ]     request valid per requester
//   req_data  [12*NREQ]  sample of requester i at bits [12i+11:12i]
//   req_ready [NREQ]     one-hot accept strobe (IDLE only)
//   rsp_valid/rsp_ready  response handshake
//   rsp_sign/exp/sig/id  registered result and originating requester
//   busy                 high whenever the scheduler is not in IDLE
module fpcvt_sched
  import fpcvt_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [DATA_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_sign,
  output logic [EXP_W-1:0]       rsp_exp,
  output logic [SIG_W-1:0]       rsp_sig,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

  state_t            state;
  logic [ID_W-1:0]   pointer;
  logic [ID_W-1:0]   id;
  logic              sign;
  logic [MAG_W-1:0]  mag;
  logic [EXP_W-1:0]  exp_cnt;

  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   sel_id;
  logic [DATA_W-1:0] sel_data;
  logic [SIG_W-1:0]  sig_trunc;
  logic              round_bit;
  logic [SIG_W-1:0]  rnd_sig;
  logic [EXP_W-1:0]  rnd_exp;
  logic [ID_W-1:0]   next_pointer;

  // Grants are only offered in IDLE and never while reset is asserted.
  fpcvt_rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .pointer   (pointer),
    .enable    ((state == IDLE) && rst_n),
    .grant     (grant)
  );

  assign req_ready = grant;

  // Turn the one-hot grant into an index and pick that requester's sample.
  always_comb begin
    sel_id   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_id   = ID_W'(i);
        sel_data = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // Round half-up on the first dropped bit. A carry out of the significand
  // renormalises to 1000 with exponent+1, unless the exponent is already at
  // its ceiling, in which case the result saturates.
  assign sig_trunc = mag[MAG_W-1 -: SIG_W];
  assign round_bit = mag[MAG_W-1-SIG_W];

  always_comb begin
    rnd_sig = sig_trunc;
    rnd_exp = exp_cnt;
    if (round_bit) begin
      if (sig_trunc != SIG_MAX) begin
        rnd_sig = sig_trunc + SIG_W'(1);
      end else if (exp_cnt != EXP_MAX) begin
        rnd_sig = {1'b1, {(SIG_W-1){1'b0}}};
        rnd_exp = exp_cnt + EXP_W'(1);
      end
    end
  end

  assign next_pointer = (id == LAST_ID) ? '0 : id + ID_W'(1);

  // Scheduler FSM with registered response and busy outputs. The pointer
  // moves only when a response completes, so every requester gets a turn.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pointer   <= '0;
      id        <= '0;
      sign      <= 1'b0;
      mag       <= '0;
      exp_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_sign  <= 1'b0;
      rsp_exp   <= '0;
      rsp_sig   <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            id      <= sel_id;
            sign    <= sel_data[DATA_W-1];
            mag     <= abs_sat(sel_data);
            exp_cnt <= EXP_MAX;
            state   <= NORM;
            busy    <= 1'b1;
          end
        end
        NORM: begin
          // Stop when the leading one reaches the top or the exponent runs out.
          if (mag[MAG_W-1] || (exp_cnt == '0)) begin
            state <= ROUND;
          end else begin
            mag     <= mag << 1;
            exp_cnt <= exp_cnt - EXP_W'(1);
          end
        end
        ROUND: begin
          rsp_sign  <= sign;
          rsp_exp   <= rnd_exp;
          rsp_sig   <= rnd_sig;
          rsp_id    <= id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            pointer   <= next_pointer;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpcvt_sched.sv
// tb_fpcvt_sched
// Scoreboard bench for fpcvt_sched (NREQ=2). The stimulus process pushes
// hand-computed expected responses (fields and latency) into a queue; a
// monitor process pops and compares whenever a response handshake is seen.
module tb_fpcvt_sched;

  localparam int NREQ = 2;
  localparam int ID_W = 1;

  typedef struct {
    logic       s;
    logic [2:0] e;
    logic [3:0] m;
    int         id;
    int         lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [12*NREQ-1:0] req_data;
  logic [NREQ-1:0]  req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_sign;
  logic [2:0]       rsp_exp;
  logic [3:0]       rsp_sig;
  logic [ID_W-1:0]  rsp_id;
  logic             busy;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   accept_cyc = 0;
  logic prev_valid = 1'b0;

  fpcvt_sched #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sign  (rsp_sign),
    .rsp_exp   (rsp_exp),
    .rsp_sig   (rsp_sig),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  // Free-running clock and an edge counter used for latency measurement.
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  task automatic pushExp(input int rid, input logic s, input logic [2:0] e,
                         input logic [3:0] m, input int lat);
    exp_t x;
    x.s = s; x.e = e; x.m = m; x.id = rid; x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample on requester rid and hold it until it is accepted.
  task automatic applyStimulus(input int rid, input logic [11:0] data, input bit expect_rsp,
                               input logic s, input logic [2:0] e, input logic [3:0] m,
                               input int lat);
    bit ok;
    if (expect_rsp) pushExp(rid, s, e, m, lat);
    req_data[12*rid +: 12] = data;
    req_valid[rid] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ready[rid]) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    req_valid[rid] = 1'b0;
    if (!ok) checkOutput("accept_timeout", 32'(req_ready[rid]), 32'd1);
  endtask

  // Wait until every expected response has been consumed and the block is idle.
  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    tick();
    if (!done) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: invariant on req_ready, latency on each rising rsp_valid, and
  // field comparison on each response handshake.
  initial forever begin
    exp_t x;
    @(negedge clk);
    if (rst_n) begin
      if (busy) checkOutput("ready_outside_idle", 32'(req_ready), 32'd0);
      if (|(req_valid & req_ready)) accept_cyc = cyc + 1;
      if (rsp_valid && !prev_valid && sb.size() > 0)
        checkOutput("latency", 32'(cyc - accept_cyc), 32'(sb[0].lat));
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          x = sb.pop_front();
          checkOutput("rsp_fields", 32'({rsp_sign, rsp_exp, rsp_sig, rsp_id}),
                      32'({x.s, x.e, x.m, ID_W'(x.id)}));
        end
      end
    end
    prev_valid = rsp_valid;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  cnt0;
    int  cnt1;
    bit  found;
    logic [NREQ-1:0] g;

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;

    // Reset: outputs cleared, no grant while reset is asserted.
    tick(); tick();
    req_valid = 2'b11;
    @(negedge clk);
    checkOutput("ready_in_reset0", 32'(req_ready), 32'd0);
    checkOutput("reset_state", 32'({rsp_valid, busy, rsp_sign, rsp_exp, rsp_sig, rsp_id}), 32'd0);
    tick();
    req_valid = 2'b00;
    rst_n = 1'b1;
    tick();

    $display("[TB] basic conversions");
    applyStimulus(0, 12'h1A6, 1'b1, 1'b0, 3'd5, 4'd13, 4);
    waitDrain();
    applyStimulus(1, 12'h07D, 1'b1, 1'b0, 3'd4, 4'd8, 6);
    waitDrain();
    applyStimulus(1, 12'hFFF, 1'b1, 1'b1, 3'd0, 4'd1, 9);
    waitDrain();
    applyStimulus(0, 12'h800, 1'b1, 1'b1, 3'd7, 4'd15, 2);
    waitDrain();
    applyStimulus(0, 12'h7FF, 1'b1, 1'b0, 3'd7, 4'd15, 2);
    waitDrain();
    applyStimulus(1, 12'h000, 1'b1, 1'b0, 3'd0, 4'd0, 9);
    waitDrain();

    // Pointer is 0 here; both requesters stay valid, grants must alternate.
    $display("[TB] round-robin alternation");
    pushExp(0, 1'b0, 3'd7, 4'd8, 2);
    pushExp(1, 1'b1, 3'd3, 4'd13, 6);
    pushExp(0, 1'b0, 3'd5, 4'd13, 4);
    pushExp(1, 1'b0, 3'd4, 4'd8, 6);
    req_data[11:0]  = 12'h400;
    req_data[23:12] = 12'hF9C;
    req_valid = 2'b11;
    cnt0 = 0;
    cnt1 = 0;
    for (int c = 0; c < 200 && (cnt0 < 2 || cnt1 < 2); c++) begin
      @(negedge clk);
      g = req_valid & req_ready;
      tick();
      if (g[0]) begin
        cnt0++;
        if (cnt0 == 1) req_data[11:0] = 12'h1A6;
        else req_valid[0] = 1'b0;
      end
      if (g[1]) begin
        cnt1++;
        if (cnt1 == 1) req_data[23:12] = 12'h07D;
        else req_valid[1] = 1'b0;
      end
    end
    req_valid = 2'b00;
    if (cnt0 < 2 || cnt1 < 2) checkOutput("alternate_timeout", 32'(cnt0 + cnt1), 32'd4);
    waitDrain();

    // Back-pressure: result must hold for 5 cycles with rsp_ready low.
    $display("[TB] response stall");
    rsp_ready = 1'b0;
    applyStimulus(0, 12'h5DC, 1'b1, 1'b0, 3'd7, 4'd12, 2);
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) checkOutput("stall_rsp_timeout", 32'(rsp_valid), 32'd1);
    tick();
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_hold",
                  32'({rsp_valid, busy, req_ready, rsp_sign, rsp_exp, rsp_sig, rsp_id}),
                  32'({1'b1, 1'b1, 2'b00, 1'b0, 3'd7, 4'd12, 1'b0}));
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    tick();
    @(negedge clk);
    checkOutput("stall_release_idle", 32'({rsp_valid, busy}), 32'd0);
    tick();

    // Pointer is 1 here. Reset during NORM must drop the sample and clear it.
    $display("[TB] reset mid-operation");
    applyStimulus(1, 12'h003, 1'b0, 1'b0, 3'd0, 4'd0, 0);
    @(negedge clk);
    tick();
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_data[11:0] = 12'hED4;
    pushExp(0, 1'b1, 3'd5, 4'd9, 4);
    @(negedge clk);
    checkOutput("ready_in_reset", 32'(req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_flush", 32'({rsp_valid, busy, req_ready}), 32'({1'b0, 1'b0, 2'b01}));
    tick();
    req_valid = 2'b00;
    waitDrain();

    @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
